// File: rtl/img_arb_pkg.sv
// Shared constants and types for the image-memory arbiter.
package img_arb_pkg;

  localparam int unsigned IMG_ADDR_W = 16;
  localparam int unsigned IMG_DATA_W = 8;
  localparam int unsigned IMG_RD_LAT = 2;
  localparam int unsigned MAX_REQ    = 4;
  localparam int unsigned PORT_IDX_W = $clog2(MAX_REQ);

  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  // One entry of the read-return tag pipeline.
  typedef struct packed {
    logic      valid;
    port_idx_t port;
  } rd_tag_t;

endpackage

// File: rtl/img_mem_arb_if.sv
// Requester and memory-pin bundle of the image-memory arbiter.
// slave: arbiter side; master: requesters plus memory side.
interface img_mem_arb_if #(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        we;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]       rdata;
  logic                    img_rd;
  logic                    img_wr;
  logic [ADDR_W-1:0]       img_addr;
  logic [DATA_W-1:0]       img_do;
  logic [DATA_W-1:0]       img_di;

  modport slave (
    input  req, we, addr, wdata, img_di,
    output gnt, rvalid, rdata, img_rd, img_wr, img_addr, img_do
  );

  modport master (
    output req, we, addr, wdata, img_di,
    input  gnt, rvalid, rdata, img_rd, img_wr, img_addr, img_do
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational one-hot grant picker: round-robin after last_i, or lowest index
// first when IMG_ARB_FIXED_PRIO_EN is defined.
module rr_pick
  import img_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) (
  input  logic [N_REQ-1:0] req_i,
`ifndef IMG_ARB_FIXED_PRIO_EN
  input  port_idx_t        last_i,
`endif
  output logic [N_REQ-1:0] gnt_o
);

`ifdef IMG_ARB_FIXED_PRIO_EN
  // Isolate the lowest set bit.
  always_comb begin
    gnt_o = req_i & (~req_i + N_REQ'(1));
  end
`else
  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        if (!found && req_i[k] && (((32'(last_i) + off) % N_REQ) == k)) begin
          gnt_o[k] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/img_mem_arb.sv
// Single-port image memory arbiter: one access per cycle, registered memory
// command, 2-cycle read return. Define IMG_ARB_FIXED_PRIO_EN for fixed priority.
module img_mem_arb
  import img_arb_pkg::*;
#(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned ADDR_W = IMG_ADDR_W,
  parameter int unsigned DATA_W = IMG_DATA_W
) (
  input logic          clk,
  input logic          reset,
  img_mem_arb_if.slave bus_io
);

  logic [N_REQ-1:0]  gnt;
  logic              acc;
  port_idx_t         acc_idx;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              img_rd_q, img_wr_q;
  logic [ADDR_W-1:0] img_addr_q;
  logic [DATA_W-1:0] img_do_q;
  rd_tag_t           tag_d;
  rd_tag_t           tag_q [IMG_RD_LAT];

`ifndef IMG_ARB_FIXED_PRIO_EN
  port_idx_t last_q, last_d;
`endif

  rr_pick #(
    .N_REQ  (N_REQ)
  ) u_pick (
    .req_i  (bus_io.req),
`ifndef IMG_ARB_FIXED_PRIO_EN
    .last_i (last_q),
`endif
    .gnt_o  (gnt)
  );

  assign acc = |(bus_io.req & gnt);

  always_comb begin
    acc_idx   = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (gnt[k]) begin
        acc_idx   = port_idx_t'(k);
        sel_we    = bus_io.we[k];
        sel_addr  = bus_io.addr[k*ADDR_W +: ADDR_W];
        sel_wdata = bus_io.wdata[k*DATA_W +: DATA_W];
      end
    end
    tag_d = '{valid: acc & ~sel_we, port: acc_idx};
`ifndef IMG_ARB_FIXED_PRIO_EN
    last_d = acc ? acc_idx : last_q;
`endif
  end

  // Async reset also flushes in-flight read tags, so no rvalid follows.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      img_rd_q   <= 1'b0;
      img_wr_q   <= 1'b0;
      img_addr_q <= '0;
      img_do_q   <= '0;
      for (int i = 0; i < IMG_RD_LAT; i++) tag_q[i] <= '0;
`ifndef IMG_ARB_FIXED_PRIO_EN
      last_q     <= port_idx_t'(N_REQ - 1);
`endif
    end else begin
      img_rd_q <= acc & ~sel_we;
      img_wr_q <= acc & sel_we;
      if (acc) begin
        img_addr_q <= sel_addr;
        img_do_q   <= sel_wdata;
      end
      tag_q[0] <= tag_d;
      for (int i = 1; i < IMG_RD_LAT; i++) tag_q[i] <= tag_q[i-1];
`ifndef IMG_ARB_FIXED_PRIO_EN
      last_q <= last_d;
`endif
    end
  end

  always_comb begin
    bus_io.rvalid = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      bus_io.rvalid[k] = tag_q[IMG_RD_LAT-1].valid &&
                         (tag_q[IMG_RD_LAT-1].port == port_idx_t'(k));
    end
  end

  assign bus_io.gnt      = gnt;
  assign bus_io.rdata    = bus_io.img_di;
  assign bus_io.img_rd   = img_rd_q;
  assign bus_io.img_wr   = img_wr_q;
  assign bus_io.img_addr = img_addr_q;
  assign bus_io.img_do   = img_do_q;

endmodule

// File: doc/img_mem_arb.md
# img_mem_arb

Arbiter that shares the single-port 256x256 8-bit image memory (65536 words, 16-bit address) among up to four requesters: a host pixel loader, the gradient engine, and spare ports. It sits between the requesters and the memory pins (`img_rd`/`img_wr`/`img_addr`/`img_do`/`img_di`). It accepts at most one access per cycle by round-robin arbitration, drives a registered memory command, and routes read data back to the issuing port with fixed latency.

## Interface
- `N_REQ`, default 2: number of requesters, legal range 2..4.
- `ADDR_W`, default 16: memory address width.
- `DATA_W`, default 8: pixel width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  reset, asynchronous, active-low.
- `req`  in  N_REQ  per-port access request.
- `we`  in  N_REQ  per-port write enable; 1 = write, 0 = read.
- `addr`  in  N_REQ*ADDR_W  flattened addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- `wdata`  in  N_REQ*DATA_W  flattened write data, packed the same way.
- `gnt`  out  N_REQ  combinational one-hot grant; an access is accepted on an edge where `req[k] && gnt[k]`.
- `rvalid`  out  N_REQ  per-port read-data-valid pulse.
- `rdata`  out  DATA_W  read data, shared by all ports; qualified by `rvalid`.
- `img_rd`  out  1  memory read strobe, registered.
- `img_wr`  out  1  memory write strobe, registered.
- `img_addr`  out  ADDR_W  memory address, registered.
- `img_do`  out  DATA_W  memory write data, registered.
- `img_di`  in  DATA_W  memory read data, valid in the cycle after `img_rd`.

## Operation
- **Requester rule:** hold `req`, `we`, `addr` and `wdata` stable from `req` rise until the accepting edge. Dropping `req` before grant withdraws the request with no side effect.
- **Grant generation:** combinational from `req` and the `last` pointer.
  - `gnt` has at most one bit set, and only on a port with `req` high.
  - Search order is `last+1`, `last+2`, ... modulo `N_REQ`.
- **`last` pointer:** updates to the accepted port on every accept and is otherwise held. Reset value is `N_REQ-1`, so port 0 has highest priority first.
- **Accept:** the next cycle drives `img_addr`/`img_do` from the accepted port.
  - `img_wr` = `we` of the accepted port.
  - `img_rd` = !`we` of the accepted port.
  - In cycles with no accept, `img_rd` = `img_wr` = 0; `img_addr`/`img_do` hold their last value.
- **Read return:** a 2-stage tag pipeline (valid bit plus port index) follows each read. `rvalid[k]` is asserted in the cycle the memory presents `img_di` for that read. `rdata` = `img_di` combinationally.
- **Writes:** no response.
- **Throughput:** one access per cycle with no bubbles, including back-to-back accepts on the same port and read/write interleaving.
- **Ordering:** memory accesses complete in accept order, so a read following a write to the same address returns the new data.

## Timing
- Accept edge at end of cycle t:
  - Memory strobe is in cycle t+1.
  - For a read, `rvalid` and data are in cycle t+2.
  - Read latency is therefore 2 cycles from accept.
- **Reset values:**
  - `img_rd` = `img_wr` = 0.
  - `img_addr` = 0, `img_do` = 0.
  - `rvalid` = 0.
  - `gnt` = 0 whenever `req` = 0.
  - `last` = `N_REQ-1`.
- **Reset mid-operation:** in-flight reads are discarded and no `rvalid` is issued for them. Requesters must reissue.
- **Simultaneous requests:** exactly one port is granted and the others wait. No port waits more than `N_REQ-1` accepts (round-robin mode).
- **Address boundaries:** no special handling; 0xFFFF is a legal address and no wrap logic exists.

## Configuration
- `IMG_ARB_FIXED_PRIO_EN` defined:
  - Lowest-index requesting port always wins.
  - The `last` pointer is not instantiated.
  - Port 0 (loader) can starve the others.
- `IMG_ARB_FIXED_PRIO_EN` undefined (default): round-robin as above.

## Structure
- **Package `img_arb_pkg`:**
  - Constants `IMG_ADDR_W`=16, `IMG_DATA_W`=8, `IMG_RD_LAT`=2, `MAX_REQ`=4.
  - Typedef for the tag-pipeline entry (valid, 2-bit port index).
- **Sub-module `rr_pick`:** purely combinational one-hot picker from `req` vector and `last` index. Under the macro it degenerates to a lowest-index-first priority encoder.
- **Top level:** accept logic, registered memory command, tag pipeline.

## Test plan
- **Reset mid-read:** port 0 read at 0x0010 accepted, `reset` low for 1 cycle in t+1 → `rvalid` stays 0, all outputs at reset values, `last` = `N_REQ-1`.
- **Single read:** only port 1 requests a read at 0x0100, memory model returns 0x5A → `gnt[1]` same cycle; `img_rd`=1, `img_addr`=0x0100 in t+1; `rvalid[1]`=1, `rdata`=0x5A in t+2.
- **Contention, round-robin:** ports 0 and 1 hold read requests for 6 cycles → grants alternate 0,1,0,1,0,1; each `rvalid` appears 2 cycles after its accept on the matching port.
- **Write then read:** port 0 writes 0x33 to 0xFFFF, then port 1 reads 0xFFFF on the next cycle → `img_wr` then `img_rd` in consecutive cycles; `rdata`=0x33 with `rvalid[1]`.
- **Fixed priority (`IMG_ARB_FIXED_PRIO_EN`):** ports 0 and 1 both request continuously for 5 cycles → `gnt[0]` every cycle, `gnt[1]` never.
- **Withdrawn request, `N_REQ`=4:** port 2 drops `req` before grant while port 3 requests → no access for port 2; port 3 is granted; `img_rd` is never driven with port 2's address.
